// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Package  : countdown_pkg
// Brief    : Shared state encoding and default timing for countdown run control.
// Revision : 1.0 - initial release
// ============================================================================
package countdown_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
    localparam logic [ST_W-1:0] ST_PAUSE = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

    // 10 ms of stable level at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage : countdown_pkg
`default_nettype wire

// File: rtl/countdown_control_if.sv
`default_nettype none
// ============================================================================
// Interface : countdown_control_if
// Brief     : Button, tick and counter-chain signals around countdown_control.
// Revision  : 1.0 - initial release
// ============================================================================
interface countdown_control_if;

    logic       btn_startstop;
    logic       btn_clear;
    logic       tick_1hz;
    logic       all_zero;
    logic       count_enable;
    logic       load;
    logic       alarm;
    logic [1:0] state;

    modport master (
        output btn_startstop,
        output btn_clear,
        output tick_1hz,
        output all_zero,
        input  count_enable,
        input  load,
        input  alarm,
        input  state
    );

    modport slave (
        input  btn_startstop,
        input  btn_clear,
        input  tick_1hz,
        input  all_zero,
        output count_enable,
        output load,
        output alarm,
        output state
    );

endinterface : countdown_control_if
`default_nettype wire

// File: rtl/countdown_control_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Brief    : Two-flop synchronizer, stable-time debouncer and one-cycle press
//            pulse on the rising edge of the debounced level.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int              DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] c_CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_level_d;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;

            // The level flips on the cycle the count of differing cycles hits the limit
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule : button_debounce
`default_nettype wire

// File: rtl/countdown_control.sv
`default_nettype none
// ============================================================================
// Module   : countdown_control
// Brief    : Run-control FSM for the countdown timer: debounced Start/Stop and
//            Clear, count enable, reload pulse and blinking 0:00 alarm.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_control
    import countdown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    countdown_control_if.slave  ctl
);

    logic [1:0]      w_levels_unused;
    logic            w_ss_press;
    logic            w_clr_press;

    logic [ST_W-1:0] r_state;
    logic            r_load;
    logic            r_alarm;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_startstop (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (ctl.btn_startstop),
        .level   (w_levels_unused[0]),
        .press   (w_ss_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_clear (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (ctl.btn_clear),
        .level   (w_levels_unused[1]),
        .press   (w_clr_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_load  <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_load <= 1'b0;
            // Clear overrides everything, including a simultaneous Start/Stop press
            if (w_clr_press) begin
                r_load  <= 1'b1;
                r_state <= ST_IDLE;
                r_alarm <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ss_press && !ctl.all_zero) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (ctl.all_zero) begin
                            r_state <= ST_DONE;
                            r_alarm <= 1'b1;
                        end else if (w_ss_press) begin
                            r_state <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        if (w_ss_press) begin
                            if (ctl.all_zero) begin
                                r_state <= ST_DONE;
                                r_alarm <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (w_ss_press) begin
                            r_state <= ST_IDLE;
                            r_alarm <= 1'b0;
                        end else if (ctl.tick_1hz) begin
                            r_alarm <= ~r_alarm;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_alarm <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Masking with all_zero keeps the counters from wrapping in the cycle before DONE
    assign ctl.count_enable = (r_state == ST_RUN) && !ctl.all_zero;
    assign ctl.load         = r_load;
    assign ctl.alarm        = r_alarm;
    assign ctl.state        = r_state;

endmodule : countdown_control
`default_nettype wire

// File: tb/tb_countdown_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_control
// Brief    : Directed self-checking bench for countdown_control (debounce = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_control;

    localparam int c_DB = 4;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_PAUSE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    countdown_control_if cif ();

    countdown_control #(
        .DEBOUNCE_CYCLES (c_DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press long enough to produce the pulse, then release and let it settle
    task automatic press_ss();
        cif.btn_startstop = 1'b1;
        wait_cycles(10);
        cif.btn_startstop = 1'b0;
        wait_cycles(10);
    endtask

    initial begin
        int stray;
        int load_cnt;
        int pause_seen;

        n_checks = 0;
        n_errors = 0;

        reset             = 1'b1;
        cif.btn_startstop = 1'b0;
        cif.btn_clear     = 1'b0;
        cif.tick_1hz      = 1'b0;
        cif.all_zero      = 1'b0;

        // 1: reset and quiet idle
        wait_cycles(3);
        check("reset_outputs", {cif.state, cif.count_enable, cif.load, cif.alarm}, 5'd0);
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            wait_cycles(1);
            if ({cif.state, cif.count_enable, cif.load, cif.alarm} != 5'd0) stray++;
        end
        check("idle_quiet", stray, 0);

        // 2: clean press from IDLE, latency 8 edges to RUN
        cif.btn_startstop = 1'b1;
        wait_cycles(7);
        check("ss_latency_early", cif.state, c_IDLE);
        wait_cycles(1);
        check("ss_to_run", cif.state, c_RUN);
        check("run_enable", cif.count_enable, 1'b1);
        stray = 0;
        for (int i = 0; i < 50; i++) begin
            wait_cycles(1);
            if (cif.state != c_RUN) stray++;
        end
        check("run_hold", stray, 0);
        cif.btn_startstop = 1'b0;
        wait_cycles(10);
        check("release_no_effect", cif.state, c_RUN);

        // 3: bounce every 2 cycles, then settle high -> single PAUSE
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            cif.btn_startstop = ~cif.btn_startstop;
            wait_cycles(2);
            if (cif.state != c_RUN) stray++;
        end
        check("bounce_ignored", stray, 0);
        cif.btn_startstop = 1'b1;
        wait_cycles(7);
        check("bounce_settle_early", cif.state, c_RUN);
        wait_cycles(1);
        check("run_to_pause", cif.state, c_PAUSE);
        check("pause_enable", cif.count_enable, 1'b0);
        wait_cycles(20);
        check("pause_hold", cif.state, c_PAUSE);
        cif.btn_startstop = 1'b0;
        wait_cycles(10);

        // 4: resume, reach 0:00, blink alarm, acknowledge
        press_ss();
        check("pause_to_run", cif.state, c_RUN);
        cif.all_zero = 1'b1;
        #1;
        check("zero_enable_comb", cif.count_enable, 1'b0);
        wait_cycles(1);
        check("run_to_done", cif.state, c_DONE);
        check("done_alarm_on", cif.alarm, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cif.tick_1hz = 1'b1;
            wait_cycles(1);
            cif.tick_1hz = 1'b0;
            check("alarm_toggle", cif.alarm, (i % 2 == 0) ? 1'b0 : 1'b1);
        end
        wait_cycles(3);
        check("alarm_no_tick", cif.alarm, 1'b0);
        cif.tick_1hz = 1'b1;
        wait_cycles(1);
        cif.tick_1hz = 1'b0;
        check("alarm_tick4", cif.alarm, 1'b1);
        press_ss();
        check("done_to_idle", cif.state, c_IDLE);
        check("done_alarm_off", cif.alarm, 1'b0);

        // 5: clear and startstop together from RUN
        cif.all_zero = 1'b0;
        press_ss();
        check("idle_to_run2", cif.state, c_RUN);
        cif.btn_clear     = 1'b1;
        cif.btn_startstop = 1'b1;
        load_cnt   = 0;
        pause_seen = 0;
        for (int i = 0; i < 20; i++) begin
            wait_cycles(1);
            if (cif.load) load_cnt++;
            if (cif.state == c_PAUSE) pause_seen++;
            if (i == 7) check("load_at_edge8", cif.load, 1'b1);
        end
        check("load_single", load_cnt, 1);
        check("clear_no_pause", pause_seen, 0);
        check("clear_to_idle", cif.state, c_IDLE);
        cif.btn_clear     = 1'b0;
        cif.btn_startstop = 1'b0;
        wait_cycles(10);
        check("clear_release", cif.state, c_IDLE);

        // 6: start refused at 0:00, then button held through reset
        cif.all_zero = 1'b1;
        press_ss();
        check("zero_start_state", cif.state, c_IDLE);
        check("zero_start_enable", cif.count_enable, 1'b0);
        cif.btn_startstop = 1'b1;
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        cif.all_zero = 1'b0;
        wait_cycles(7);
        check("held_reset_early", cif.state, c_IDLE);
        wait_cycles(1);
        check("held_reset_press", cif.state, c_RUN);
        wait_cycles(30);
        check("held_reset_once", cif.state, c_RUN);
        cif.btn_startstop = 1'b0;
        wait_cycles(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_countdown_control
`default_nettype wire

// File: doc/countdown_control.md
Name: countdown_control

Overview:
Run-control stage directly upstream of the seconds/tens/minutes downcounter chain in the countdown timer. It debounces the raw Start/Stop and Clear pushbuttons and runs a four-state FSM (IDLE/RUN/PAUSE/DONE). It drives the counters' count enable and a synchronous reload pulse, and raises a 1 Hz blinking alarm when the count reaches 0:00. It runs on the single system clock and uses a one-cycle 1 Hz tick strobe, not a divided clock.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required before a debounced button level changes (10 ms at 100 MHz).
DB_W, $clog2(DEBOUNCE_CYCLES+1), width of the debounce counter; derived, not overridden.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
btn_startstop  input  1  raw Start/Stop pushbutton, asynchronous, bouncy, active-high
btn_clear  input  1  raw Clear pushbutton, asynchronous, bouncy, active-high
tick_1hz  input  1  one-clk-cycle strobe once per second, from the clock-enable generator
all_zero  input  1  high when seconds, tens and minutes counters are all 0
count_enable  output  1  enable to the seconds downcounter; counters decrement only when this and tick_1hz are both high
load  output  1  one-cycle pulse; counters reload start values (minutes from switches, seconds/tens to 0)
alarm  output  1  blinking alarm LED drive
state  output  2  FSM state for debug LEDs: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE, count_enable=0, load=0, alarm=0. Synchronizer flops, debounced levels and debounce counters = 0.
- Per button: 2-flop synchronizer, then debouncer.
  - Debounce counter increments each cycle the synchronized level differs from the debounced level.
  - Counter clears to 0 on any cycle the two levels match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
- Press pulse = registered rising edge of the debounced level; exactly one cycle wide.
- A clean raw 0->1 edge yields the press pulse DEBOUNCE_CYCLES+3 clk edges after the first edge that samples raw high.
- Releases generate no pulse. A hold of any length generates exactly one pulse.
- A button held through reset release is seen as a fresh press: one pulse after the debounce delay.
- FSM, registered. Priority in every state: clear press > all_zero-driven exit > startstop press.
  - Any state + clear press: load=1 for that one cycle; next state IDLE; alarm cleared.
  - IDLE + startstop press: -> RUN if all_zero=0. If all_zero=1, stay IDLE (nothing to count).
  - RUN + all_zero=1: -> DONE.
  - RUN + startstop press (all_zero=0): -> PAUSE.
  - PAUSE + startstop press: -> RUN if all_zero=0, else -> DONE.
  - DONE: alarm set to 1 on the entry edge, then toggles on each tick_1hz while in DONE. Startstop press -> IDLE with alarm=0.
- count_enable = (state==RUN) & ~all_zero, combinational from registered state. The counters can never decrement past 0:00, even in the cycle before the FSM enters DONE.
- load is registered and is the only source of reload. It has no effect on state beyond the transition to IDLE.
- tick_1hz is ignored in all states except DONE (alarm toggle). The block never gates or delays the tick itself.
- A clear press and a startstop press in the same cycle: one load pulse, state IDLE; the startstop press is discarded.

Decomposition:
- Package countdown_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3;
  - default DEBOUNCE_CYCLES constant.
- Sub-module button_debounce (params DEBOUNCE_CYCLES; ports clk, reset, btn_raw, level, press).
  - Contains synchronizer, debounce counter and edge detect.
  - Instantiated twice.
- The FSM and output logic live in countdown_control.

Test Plan (DEBOUNCE_CYCLES=4, so press latency is 7 edges):
1. Reset held 3 cycles, then released with buttons low -> state=0, count_enable=0, load=0, alarm=0; stays so for 20 cycles with no stimulus.
2. IDLE, all_zero=0, btn_startstop 0->1 clean -> state=1 exactly 8 edges after the first sampling edge (press pulse plus FSM register); count_enable=1. Hold 50 cycles -> no further state change.
3. RUN, btn_startstop toggles every 2 cycles for 20 cycles, then settles high -> state never changes during bouncing; exactly one transition to PAUSE (2) after settling.
4. RUN, all_zero raised -> count_enable=0 in the same cycle; state=3 next edge; alarm=1. Three tick_1hz strobes -> alarm 0, 1, 0. Startstop press -> state=0, alarm=0.
5. RUN, btn_clear and btn_startstop raised on the same edge -> load high for exactly one cycle; state=0; no PAUSE.
6. IDLE, all_zero=1, startstop press -> state stays 0, count_enable stays 0. Separately, btn_startstop held high across reset release -> exactly one press is seen after reset.
